// File: rtl/mux_reg_n.sv
// Registered N-way channel multiplexer with a valid/ready output stage (full throughput).
// Define MUX_REG_N_SEL_CHECK_EN to reject out-of-range selects and raise sticky err_sel.
module mux_reg_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_p1;
  state_t             state_nxt;
  logic [WIDTH-1:0]   data_p1;
  logic [SEL_W-1:0]   sel_p1;
  logic               accept;
  logic               load;
  logic               drain;

  // Unmatched select values fall through to channel 0.
  function automatic logic [WIDTH-1:0] pick_channel(
    input logic [NUM_IN*WIDTH-1:0] bus,
    input logic [SEL_W-1:0]        s
  );
    pick_channel = bus[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (int'(s) == k) pick_channel = bus[k*WIDTH +: WIDTH];
    end
  endfunction

  assign in_ready  = (state_p1 == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign drain     = (state_p1 == FULL) && out_ready;
  assign out_valid = (state_p1 == FULL);
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

`ifdef MUX_REG_N_SEL_CHECK_EN
  logic sel_ok;
  logic err_p1;

  function automatic logic in_range(input logic [SEL_W-1:0] s);
    in_range = (int'(s) < NUM_IN);
  endfunction

  assign sel_ok  = in_range(sel);
  // A bad select still completes the handshake but never loads the register.
  assign load    = accept && sel_ok;
  assign err_sel = err_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_p1 <= 1'b0;
    end else if (accept && !sel_ok) begin
      err_p1 <= 1'b1;
    end
  end
`else
  assign load    = accept;
  assign err_sel = 1'b0;
`endif

  always_comb begin
    state_nxt = state_p1;
    if (load) begin
      state_nxt = FULL;
    end else if (drain) begin
      state_nxt = EMPTY;
    end
  end

  // Stage p1: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= EMPTY;
      data_p1  <= '0;
      sel_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (load) begin
        data_p1 <= pick_channel(in_data, sel);
        sel_p1  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mux_reg_n.sv
// Directed and randomized scoreboard bench for mux_reg_n (WIDTH=8, NUM_IN=3).
module tb_mux_reg_n;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_sel;

  int n_assert;
  int n_fail;

  mux_reg_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .sel(sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_sel(err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SEL_W+WIDTH-1:0] sb_q[$];
    logic [SEL_W+WIDTH-1:0] exp_item;
    logic [WIDTH-1:0]       ch;

    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_data   = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_err_sel", 32'(err_sel), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Scenario 1: select channel 1
    in_data   = {8'h00, 8'h2A, 8'h15};
    sel       = 2'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("s1_out_data", 32'(out_data), 32'h2A);
    check("s1_out_sel", 32'(out_sel), 32'd1);
    check("s1_out_valid", 32'(out_valid), 32'd1);
    step();
    check("s1_drain_valid", 32'(out_valid), 32'd0);
    check("s1_empty_hold", 32'(out_data), 32'h2A);

    // Scenario 2: stall holds output while inputs churn
    in_data   = {8'h5C, 8'h11, 8'h22};
    sel       = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    check("s2_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      in_data = 24'(32'hA1B2C3 * (i + 3));
      sel     = 2'(i);
      step();
      check("s2_hold_data", 32'(out_data), 32'h5C);
      check("s2_hold_sel", 32'(out_sel), 32'd2);
      check("s2_hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("s2_drain", 32'(out_valid), 32'd0);

    // Scenario 3: back-to-back selects 0,1,2,3
    in_data   = {8'h33, 8'h22, 8'h11};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sel = 2'd0; step();
    check("s3_sel0", 32'(out_sel), 32'd0);
    check("s3_data0", 32'(out_data), 32'h11);
    check("s3_valid0", 32'(out_valid), 32'd1);
    sel = 2'd1; step();
    check("s3_sel1", 32'(out_sel), 32'd1);
    check("s3_data1", 32'(out_data), 32'h22);
    check("s3_valid1", 32'(out_valid), 32'd1);
    sel = 2'd2; step();
    check("s3_sel2", 32'(out_sel), 32'd2);
    check("s3_data2", 32'(out_data), 32'h33);
    check("s3_valid2", 32'(out_valid), 32'd1);
    sel = 2'd3; step();
`ifdef MUX_REG_N_SEL_CHECK_EN
    check("s3_bad_sel_hold", 32'(out_sel), 32'd2);
    check("s3_bad_data_hold", 32'(out_data), 32'h33);
    check("s3_bad_drained", 32'(out_valid), 32'd0);
    check("s3_bad_err", 32'(err_sel), 32'd1);
`else
    check("s3_sel3", 32'(out_sel), 32'd3);
    check("s3_data3", 32'(out_data), 32'h11);
    check("s3_valid3", 32'(out_valid), 32'd1);
    check("s3_err", 32'(err_sel), 32'd0);
`endif
    in_valid = 1'b0;
    step();
    check("s3_drain", 32'(out_valid), 32'd0);

    // Scenario 5: out-of-range select while EMPTY
    in_data  = {8'h66, 8'h44, 8'h99};
    sel      = 2'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("s5_preload", 32'(out_data), 32'h44);
    out_ready = 1'b0;
    sel       = 2'd3;
    in_valid  = 1'b1;
    #1;
    check("s5_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
`ifdef MUX_REG_N_SEL_CHECK_EN
    check("s5_err", 32'(err_sel), 32'd1);
    check("s5_data_kept", 32'(out_data), 32'h44);
    check("s5_valid", 32'(out_valid), 32'd0);
    sel      = 2'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("s5_err_sticky", 32'(err_sel), 32'd1);
    check("s5_next_data", 32'(out_data), 32'h66);
`else
    check("s5_err", 32'(err_sel), 32'd0);
    check("s5_data_ch0", 32'(out_data), 32'h99);
    check("s5_sel", 32'(out_sel), 32'd3);
    check("s5_valid", 32'(out_valid), 32'd1);
`endif

    // Scenario 4: asynchronous reset between edges while FULL
    sel      = 2'd1;
    in_data  = {8'h0F, 8'hBE, 8'h01};
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("s4_full", 32'(out_valid), 32'd1);
    check("s4_loaded", 32'(out_data), 32'hBE);
    #2;
    rst = 1'b1;
    #1;
    check("s4_async_valid", 32'(out_valid), 32'd0);
    check("s4_async_data", 32'(out_data), 32'd0);
    check("s4_async_sel", 32'(out_sel), 32'd0);
    check("s4_async_err", 32'(err_sel), 32'd0);
    step();
    check("s4_no_accept_in_rst", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("s4_post_rst_ready", 32'(in_ready), 32'd1);

    // Scenario 6: random handshakes against a scoreboard
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, NUM_IN - 1));
      in_data   = 24'($urandom);
      #1;
      check("s6_valid_model", 32'(out_valid), 32'(sb_q.size() != 0));
      if (out_valid && out_ready && sb_q.size() != 0) begin
        exp_item = sb_q.pop_front();
        check("s6_item", 32'({out_sel, out_data}), 32'(exp_item));
      end
      if (in_valid && in_ready) begin
        ch = in_data[int'(sel)*WIDTH +: WIDTH];
        sb_q.push_back({sel, ch});
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("s6_queue_empty", 32'(sb_q.size()), 32'd0);
    check("s6_final_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
